// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result-memory drain stage.
package result_drain_pkg;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_WORDS  = 80;
  localparam int DEF_FIFO_DEPTH = 4;

  // Edges between driving addrO and the returned word entering the FIFO.
  localparam int RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/result_drain_if.sv
// Core-side read port plus downstream valid/ready stream of the drain stage.
interface result_drain_if
  import result_drain_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              ap_done;
  logic [ADDR_W-1:0] addrO;
  logic [DATA_W-1:0] dataO;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              drain_done;

  modport master (
    input  ap_done, dataO, m_ready,
    output addrO, m_valid, m_data, m_last, busy, drain_done
  );

  modport slave (
    output ap_done, dataO, m_ready,
    input  addrO, m_valid, m_data, m_last, busy, drain_done
  );
endinterface

// File: rtl/result_drain_sync_fifo.sv
// Small synchronous FIFO with fall-through head and occupancy count.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wptr, rptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only safe when the head leaves at the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (do_pop) rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

`ifndef SYNTHESIS
  push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
`endif

endmodule

// File: rtl/result_drain.sv
// Sweeps the core result memory after ap_done rises and streams it out with
// credit-based issue so the skid FIFO can never overflow.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst,
  result_drain_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state;
  logic              hist;
  logic [ADDR_W-1:0] rd_ptr;
  logic [RD_LAT:1]   vld_pipe;
  logic [RD_LAT:1]   last_pipe;
  logic [CNT_W-1:0]  inflight;

  logic              start, credit, issue, issue_last;
  logic [ADDR_W-1:0] issue_addr;
  logic [CNT_W:0]    outstanding;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_head;

  // Reads in flight are reserved FIFO slots, so issue only while space remains.
  always_comb begin
    start       = bus.ap_done & ~hist;
    outstanding = {1'b0, fifo_count} + {1'b0, inflight};
    credit      = outstanding < (CNT_W + 1)'(FIFO_DEPTH);
    issue_addr  = (state == IDLE) ? '0 : rd_ptr;
    issue       = 1'b0;
    case (state)
      IDLE:    issue = start & credit;
      DRAIN:   issue = credit;
      default: issue = 1'b0;
    endcase
    issue_last  = issue && (issue_addr == LAST_ADDR);
  end

  assign push = vld_pipe[RD_LAT];
  assign pop  = bus.m_valid & bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hist           <= 1'b1;
      rd_ptr         <= '0;
      vld_pipe       <= '0;
      last_pipe      <= '0;
      inflight       <= '0;
      bus.addrO      <= '0;
      bus.busy       <= 1'b0;
      bus.drain_done <= 1'b0;
    end else begin
      hist           <= bus.ap_done;
      vld_pipe       <= {vld_pipe[RD_LAT-1:1], issue};
      last_pipe      <= {last_pipe[RD_LAT-1:1], issue_last};
      inflight       <= inflight + CNT_W'(issue) - CNT_W'(push);
      bus.drain_done <= 1'b0;
      if (issue) begin
        bus.addrO <= issue_addr;
        rd_ptr    <= issue_addr + ADDR_W'(1);
      end
      case (state)
        IDLE: if (start) begin
          bus.busy <= 1'b1;
          if (!issue) rd_ptr <= '0;
          state <= issue_last ? FLUSH : DRAIN;
        end
        DRAIN: if (issue_last) state <= FLUSH;
        // An empty FIFO means no word is on the output, so no handshake is open.
        FLUSH: if (fifo_empty && inflight == '0) begin
          state          <= DONE;
          bus.busy       <= 1'b0;
          bus.drain_done <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({last_pipe[RD_LAT], bus.dataO}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.m_valid = ~fifo_empty;
  assign {bus.m_last, bus.m_data} = fifo_head;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: random/pattern backpressure against a
// memory-sweep reference, plus reset, retrigger and single-word cases.
module tb_result_drain;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int N      = 80;
  localparam int D      = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  result_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  result_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(N), .FIFO_DEPTH(D))
    dut (.clk(clk), .rst(rst), .bus(bus));
  result_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(1), .FIFO_DEPTH(D))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    bus.dataO  <= mem[bus.addrO];
    bus1.dataO <= mem[bus1.addrO];
  end

  int n_chk = 0, n_fail = 0;
  logic [DATA_W:0] sb [$];
  int run_acc = 0, done_cnt = 0, rmode = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W:0] prev_word;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference: a run delivers mem[0..N-1] in order, last flag on the final word.
  function automatic void push_exp();
    for (int i = 0; i < N; i++) sb.push_back({(i == N - 1), mem[i]});
  endfunction

  function automatic void load_ramp();
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(i - 40);
  endfunction

  // Downstream ready generator.
  initial begin
    logic [3:0] pat;
    int rcyc;
    pat = 4'b1001;
    rcyc = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = pat[rcyc % 4];
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        run_acc = 0;
        continue;
      end
      if (!bus.busy) run_acc = 0;
      else check("outstanding_le_depth", ((int'(bus.addrO) + 1 - run_acc) <= D), 1);
      if (prev_stall)
        check("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, prev_word});
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", {bus.m_last, bus.m_data});
        end else begin
          check("word", {bus.m_last, bus.m_data}, sb.pop_front());
        end
        run_acc++;
      end
      if (bus.drain_done) done_cnt++;
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_word  = {bus.m_last, bus.m_data};
    end
  end

  task automatic start_run();
    @(posedge clk);
    #1 bus.ap_done = 1'b1;
    push_exp();
    @(posedge clk);
    #1 bus.ap_done = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string nm);
    int t;
    t = 0;
    while (done_cnt == prev && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check({nm, "_finished"}, (done_cnt != prev), 1);
    repeat (5) @(posedge clk);
    check({nm, "_done_once"}, done_cnt - prev, 1);
    check({nm, "_sb_empty"}, sb.size(), 0);
    check({nm, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int prev, t, acc, dn;
    load_ramp();
    rst = 1'b1;
    bus.ap_done = 1'b1;
    bus1.ap_done = 1'b0;
    bus1.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_values", {bus.addrO, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.drain_done}, '0);
    rst = 1'b0;

    // ap_done already high at reset release must not start a drain.
    repeat (10) @(posedge clk);
    #1;
    check("no_start_high_at_reset", {bus.busy, bus.m_valid}, 0);
    bus.ap_done = 1'b0;
    repeat (2) @(posedge clk);

    // Timed run, ready held high.
    rmode = 0;
    prev = done_cnt;
    @(posedge clk);
    #1 bus.ap_done = 1'b1;
    push_exp();
    @(posedge clk);  // start edge T
    #1 bus.ap_done = 0;
    @(negedge clk);
    check("busy_after_start", bus.busy, 1);
    @(negedge clk);
    check("valid_low_T1", bus.m_valid, 0);
    @(negedge clk);
    check("valid_high_T2", bus.m_valid, 1);
    repeat (N) @(negedge clk);
    check("done_low_T3N", {bus.busy, bus.drain_done}, 2'b10);
    @(negedge clk);
    check("done_high_T4N", {bus.busy, bus.drain_done}, 2'b01);
    wait_done(prev, "ready_high");

    // 1,0,0,1 backpressure.
    rmode = 1;
    prev = done_cnt;
    start_run();
    wait_done(prev, "pattern");

    // Extra ap_done edges while busy.
    rmode = 2;
    prev = done_cnt;
    start_run();
    repeat (3) begin
      repeat (5) @(posedge clk);
      #1 bus.ap_done = 1'b1;
      @(posedge clk);
      #1 bus.ap_done = 1'b0;
    end
    wait_done(prev, "retrigger");

    // Random data, random backpressure.
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    prev = done_cnt;
    start_run();
    wait_done(prev, "random");

    // Reset after 20 accepted words.
    load_ramp();
    prev = done_cnt;
    start_run();
    t = 0;
    while (run_acc < 20 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("reached_20_words", (run_acc >= 20), 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_values", {bus.addrO, bus.m_data, bus.m_valid, bus.m_last, bus.busy, bus.drain_done}, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rmode = 0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_quiet", {bus.m_valid, bus.busy}, 0);
    check("midrst_no_done", done_cnt - prev, 0);
    prev = done_cnt;
    start_run();
    wait_done(prev, "after_rst");

    // NUM_WORDS=1 instance, stalled for 10 cycles.
    @(posedge clk);
    #1 bus1.ap_done = 1'b1;
    @(posedge clk);
    #1 bus1.ap_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      check("n1_hold", {bus1.m_valid, bus1.m_last, bus1.m_data}, {1'b1, 1'b1, mem[0]});
    end
    @(posedge clk);
    #1 bus1.m_ready = 1'b1;
    acc = 0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus1.m_valid && bus1.m_ready) begin
        acc++;
        check("n1_word", {bus1.m_last, bus1.m_data}, {1'b1, mem[0]});
      end
      if (bus1.drain_done) dn++;
    end
    check("n1_words", acc, 1);
    check("n1_done", dn, 1);
    check("n1_idle", bus1.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/result_drain.md
# result_drain

Output-side drain stage for the systolic array core `top`. When the core raises `ap_done`, this block sweeps the core's result memory through `addrO`/`dataO`, absorbing its 1-cycle read latency. It streams every result word, in address order, onto a valid/ready interface with a last flag, so downstream logic can take the results without scripting the address sweep.

## Interface
Parameters:
- `ADDR_W`, 7: width of `addrO`; must match the core.
- `DATA_W`, 32: result word width; must match `dataO`.
- `NUM_WORDS`, 80: words drained per run, addresses 0..NUM_WORDS-1; 1 ≤ NUM_WORDS ≤ 2^ADDR_W.
- `FIFO_DEPTH`, 4: skid FIFO entries; power of two, ≥ 4.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `ap_done` in 1: core completion level; a rising edge starts a drain.
- `addrO` out ADDR_W: result-memory read address, registered.
- `dataO` in DATA_W: result-memory read data. Valid in the cycle after the edge that sampled `addrO`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DATA_W: output word, bit-exact copy of `dataO`; no sign handling.
- `m_last` out 1: high with the word from address NUM_WORDS-1.
- `busy` out 1: high from drain start until `drain_done`.
- `drain_done` out 1: one-cycle pulse after the last word is accepted.

## Operation
- Reset values:
  - `addrO`, `m_data`: 0
  - `m_valid`, `m_last`, `busy`, `drain_done`: 0
  - FSM: IDLE
  - FIFO: empty
  - in-flight counter: 0
  - `ap_done` history register: **1**. A level already high at reset release does not start a drain; `ap_done` must drop and rise again.
- Start condition: `ap_done`=1 and history=0 at an edge. The history register updates every cycle in every state.
- FSM states:
  - IDLE: on start condition, go to DRAIN, set rd_ptr=0, `busy`=1. All other inputs are ignored.
  - DRAIN: issue a read when `FIFO_count + inflight < FIFO_DEPTH`.
    - An issue drives `addrO`=rd_ptr and increments rd_ptr. Each issued read lands in the FIFO exactly 2 edges later.
    - After the issue of address NUM_WORDS-1, go to FLUSH.
    - `addrO` holds its last value when not issuing.
  - FLUSH: no issues. When the FIFO is empty, inflight=0 and no handshake is pending, go to DONE.
  - DONE: `drain_done`=1 for one cycle, `busy`=0, go to IDLE.
- `ap_done` edges while `busy` are ignored; a run is never restarted mid-drain.
- FIFO entries are {last, data}. The last bit is set on the entry whose read address was NUM_WORDS-1.
- `m_valid` = FIFO non-empty. The output is the FIFO head. A pop happens on `m_valid & m_ready`.
- A simultaneous FIFO push and pop at the same edge is legal and leaves the count unchanged.
- The full-FIFO push case is unreachable by credit; the implementation asserts on it in simulation.
- Reset mid-drain: immediate return to IDLE, FIFO flushed, in-flight reads discarded, no `drain_done`.

## Timing
- Let edge T be the start edge. `addrO`=0 is driven in cycle T..T+1. The core reads at T+1, and the block pushes at T+2.
- With `m_ready` held high:
  - `m_valid` rises after T+2.
  - Words are accepted at edges T+3 through T+2+NUM_WORDS, one per cycle with no bubbles.
  - `drain_done` is high in the cycle after edge T+3+NUM_WORDS.
- Backpressure: `m_data`/`m_last` stay stable while `m_valid & !m_ready`. No word is dropped or duplicated.
- Every `m_valid=1` cycle with `m_ready=1` transfers exactly one word.

## Structure
- Package `result_drain_pkg`:
  - state typedef: IDLE, DRAIN, FLUSH, DONE
  - read-latency constant `RD_LAT`=2
  - default widths
- Sub-module `sync_fifo`:
  - parameterised width/depth
  - push/pop/full/empty/count
  - asynchronous active-high reset
- Top-level logic: FSM, rd_ptr, inflight counter, a 2-stage issue/last shift register aligned with `RD_LAT`, and the edge detector.

## Test plan
- Preload result memory with mem[i] = i−40 (signed), pulse `ap_done`, hold `m_ready`=1.
  - Required: 80 words −40..39 in order.
  - Required: `m_last` only on the word 39.
  - Required: first `m_valid` 2 cycles after the start edge; `drain_done` as in Timing.
- Same run with `m_ready` toggling 1,0,0,1 repeating.
  - Required: identical 80-word sequence.
  - Required: `m_data` stable during every stall; never more than `FIFO_DEPTH` reads outstanding.
- Drive `ap_done` high through reset release.
  - Required: no drain.
  - Required: after `ap_done` goes low then high, exactly one 80-word drain.
- Extra `ap_done` rising edges mid-drain.
  - Required: ignored; exactly 80 words and one `drain_done`.
- Assert `rst` after 20 words accepted.
  - Required: outputs go to reset values immediately; no further `m_valid`.
  - Required: a new `ap_done` edge yields a full 0..79 drain.
- NUM_WORDS=1, `m_ready`=0 for 10 cycles then 1.
  - Required: one word with `m_last`=1, held 10 cycles, then `drain_done`.
